mem_access_ctrl: RTL and testbench

Request-side initiator for the 16-entry × 64-bit register-file memory. It accepts load/store requests over a valid/ready channel, drives the memory's `addr`/`in`/`we` pins, samples the memory's combinational read port, and returns read data or write acknowledgements over a valid/ready response channel. It sits between a core's load/store path and the memory, and it owns all sequencing of memory accesses.

---
 rtl/mem_access_ctrl.sv | 92 +++++++++
 tb/tb_mem_access_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a 2^DEPTH_LOG2-entry register-file memory with a combinational read port.
// Define MEM_ACCESS_BURST_EN to honour req_len (1-16 beat bursts); otherwise every access is one beat.
module mem_access_ctrl #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DW         = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DEPTH_LOG2-1:0] req_addr,
    input  logic [3:0]            req_len,
    input  logic [DW-1:0]         req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DW-1:0]         rsp_data,
    output logic                  rsp_wr,
    output logic                  rsp_last,
    output logic [63:0]           mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic                  mem_we,
    input  logic [DW-1:0]         mem_rdata
);
    typedef enum logic [2:0] {IDLE, WR, ACK, RD, RESP} state_t;

    state_t                state, state_nx;
    logic [DEPTH_LOG2-1:0] cur_addr;
    logic [DW-1:0]         wdata_q, rdata_q;
    logic                  accept, last_beat, advance;

    assign accept  = req_valid && (state == IDLE);
    assign advance = !last_beat && ((state == WR) || (state == RESP && rsp_ready));

`ifdef MEM_ACCESS_BURST_EN
    logic [3:0] beats_left;
    assign last_beat = (beats_left == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          beats_left <= 4'd0;
        else if (accept)  beats_left <= req_len;
        else if (advance) beats_left <= beats_left - 4'd1;
    end
`else
    logic unused_len;
    assign unused_len = ^req_len;
    assign last_beat  = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req_valid) state_nx = req_we ? WR : RD;
            WR:   if (last_beat) state_nx = ACK;
            ACK:  if (rsp_ready) state_nx = IDLE;
            RD:   state_nx = RESP;
            RESP: if (rsp_ready) state_nx = last_beat ? IDLE : RD;
            default: state_nx = IDLE;
        endcase
    end

    // Address wraps naturally at the counter width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                cur_addr <= req_addr;
                wdata_q  <= req_wdata;
            end else if (advance) begin
                cur_addr <= cur_addr + DEPTH_LOG2'(1);
            end
            if (state == RD) rdata_q <= mem_rdata;
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == ACK) || (state == RESP);
    assign rsp_wr    = (state == ACK);
    assign rsp_last  = (state == ACK) || (state == RESP && last_beat);
    assign rsp_data  = (state == RESP) ? rdata_q : '0;
    assign mem_we    = (state == WR);
    assign mem_addr  = 64'(cur_addr);
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a 16x64 behavioural memory and a response scoreboard.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [3:0]  req_addr = '0, req_len = '0;
    logic [63:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_wr, rsp_last, mem_we;
    logic [63:0] rsp_data, mem_addr, mem_wdata, mem_rdata;

    mem_access_ctrl #(.DEPTH_LOG2(4), .DW(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_wr(rsp_wr), .rsp_last(rsp_last),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [16];
    always @(posedge clk) if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[3:0]];

    typedef struct { logic [63:0] d; logic wr; logic last; } exp_t;
    typedef struct { logic we; logic [3:0] addr; logic [63:0] wdata; logic [63:0] exp; } vec_t;

    exp_t       q[$];
    exp_t       e;
    int         total = 0, bad = 0, we_cnt = 0;
    logic [3:0] we_addr = '0;

    function automatic int blen(input int len);
`ifdef MEM_ACCESS_BURST_EN
        return len;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic wr, input logic last);
        exp_t x;
        x.d = d; x.wr = wr; x.last = last;
        q.push_back(x);
    endtask

    // Scoreboard: handshakes are sampled mid-cycle, the transfer happens on the following edge.
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            we_addr = mem_addr[3:0];
        end
        if (!rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL rsp_unexpected got=%h want=none", rsp_data);
            end else begin
                e = q.pop_front();
                check("rsp_data", rsp_data, e.d);
                check("rsp_wr", 64'(rsp_wr), 64'(e.wr));
                check("rsp_last", 64'(rsp_last), 64'(e.last));
            end
        end
    end

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic we, input logic [3:0] a, input logic [3:0] len, input logic [63:0] d);
        int n = 0;
        while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin total++; bad++; $display("FAIL send_timeout got=busy want=idle"); end
        req_valid = 1'b1; req_we = we; req_addr = a; req_len = len; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("req_ready_fall", 64'(req_ready), 64'd0);
    endtask

    task automatic wait_rsp(input string nm, input int exp_cyc);
        int n = 0;
        while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
        check(nm, 64'(n), 64'(exp_cyc));
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!(req_ready && q.size() == 0) && n < 300) begin @(posedge clk); #1; n++; end
        if (n >= 300) begin total++; bad++; $display("FAIL %s_timeout got=busy want=idle", nm); end
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, 4'd3,  64'hDEADBEEF_CAFEF00D, 64'h0};
        tbl[1] = '{1'b0, 4'd3,  64'h0, 64'hDEADBEEF_CAFEF00D};
        tbl[2] = '{1'b1, 4'd0,  64'h01234567_89ABCDEF, 64'h0};
        tbl[3] = '{1'b1, 4'd15, 64'hFFFF0000_FFFF0000, 64'h0};
        tbl[4] = '{1'b0, 4'd15, 64'h0, 64'hFFFF0000_FFFF0000};
        tbl[5] = '{1'b0, 4'd0,  64'h0, 64'h01234567_89ABCDEF};
        tbl[6] = '{1'b1, 4'd3,  64'h00000000_00000001, 64'h0};
        tbl[7] = '{1'b0, 4'd3,  64'h0, 64'h00000000_00000001};
        for (int i = 0; i < 16; i++) mem[i] = '0;

        @(posedge clk); #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_rsp_flags", {62'd0, rsp_wr, rsp_last}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single-beat table: write acks, read-backs, address boundaries
        foreach (tbl[i]) begin
            we_cnt = 0;
            push(tbl[i].we ? 64'd0 : tbl[i].exp, tbl[i].we, 1'b1);
            send(tbl[i].we, tbl[i].addr, 4'd0, tbl[i].wdata);
            wait_rsp("single_latency", 1);
            wait_idle("single");
            if (tbl[i].we) begin
                check("single_we_cycles", 64'(we_cnt), 64'd1);
                check("single_we_addr", 64'(we_addr), 64'(tbl[i].addr));
            end
        end

        // Burst read across the wrap point
        for (int i = 0; i < 16; i++) mem[i] = 64'(i);
        for (int i = 0; i <= blen(3); i++) begin
            logic [3:0] a;
            a = 4'd14 + 4'(i);
            push(64'(a), 1'b0, i == blen(3));
        end
        send(1'b0, 4'd14, 4'd3, 64'd0);
        wait_rsp("burst_rd_latency", 1);
        wait_idle("burst_rd");

        // Response back-pressure holds everything still
        rsp_ready = 1'b0;
        push(64'd5, 1'b0, 1'b1);
        send(1'b0, 4'd5, 4'd0, 64'd0);
        wait_rsp("bp_latency", 1);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_data", rsp_data, 64'd5);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_mem_addr", mem_addr, 64'd5);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        wait_idle("bp");

        // Burst write fill of the whole array
        for (int i = 0; i < 16; i++) mem[i] = 64'h100 + 64'(i);
        we_cnt = 0;
        push(64'd0, 1'b1, 1'b1);
        send(1'b1, 4'd0, 4'd15, 64'hA5);
        wait_rsp("fill_latency", blen(15) + 1);
        wait_idle("fill");
        check("fill_we_cycles", 64'(we_cnt), 64'(blen(15) + 1));
        for (int i = 0; i < 16; i++) begin
            push((i <= blen(15)) ? 64'hA5 : 64'h100 + 64'(i), 1'b0, 1'b1);
            send(1'b0, 4'(i), 4'd0, 64'd0);
            wait_idle("fill_rd");
        end

        // Reset in the second cycle of a 4-beat write
        for (int i = 8; i < 12; i++) mem[i] = 64'h1000 + 64'(i);
        send(1'b1, 4'd8, 4'd3, 64'h77);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_mem_we", 64'(mem_we), 64'd0);
        check("abort_req_ready", 64'(req_ready), 64'd1);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 8; i < 12; i++) begin
            push((i == 8) ? 64'h77 : 64'h1000 + 64'(i), 1'b0, 1'b1);
            send(1'b0, 4'(i), 4'd0, 64'd0);
            wait_idle("abort_rd");
        end

        // req_len honoured only with bursts enabled
        for (int i = 0; i < 16; i++) mem[i] = 64'h200 + 64'(i);
        for (int i = 0; i <= blen(7); i++) push(64'h200 + 64'(2 + i), 1'b0, i == blen(7));
        send(1'b0, 4'd2, 4'd7, 64'd0);
        wait_idle("len7");

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
